adf_serial_rx: RTL



---
 rtl/adf_serial_rx_pkg.sv | 24 ++
 rtl/adf_serial_rx_sync_edge.sv | 32 +++
 rtl/adf_serial_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adf_serial_rx_pkg.sv
// Shared constants for the ADF4360-style 3-wire serial receiver.
package adf_serial_rx_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [1:0] ADDR_CTRL = 2'b00;
  localparam logic [1:0] ADDR_R    = 2'b01;
  localparam logic [1:0] ADDR_N    = 2'b10;

  localparam int         CNT_W   = 5;
  localparam logic [4:0] CNT_MAX = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LATCH = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 5'd1;
  endfunction

endpackage

// File: rtl/adf_serial_rx_sync_edge.sv
// Two-flop synchronizer with a rising-edge strobe; the strobe is usable
// by downstream logic at the third in_clk edge after the pin rises.
module adf_serial_rx_sync_edge
  import adf_serial_rx_pkg::*;
(
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_d,
  output logic out_lvl,
  output logic out_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_meta <= LOW;
      r_sync <= LOW;
      r_prev <= LOW;
    end else begin
      r_meta <= in_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign out_lvl  = r_sync;
  assign out_rise = r_sync & ~r_prev;

endmodule

// File: rtl/adf_serial_rx.sv
// 3-wire (SCLK/DATA/LE) serial load receiver: shifts in MSB-first words and
// commits legal ones to the R, control or N shadow register on LE.
module adf_serial_rx
  import adf_serial_rx_pkg::*;
#(
  parameter int P_WORD_BITS = 24,
  parameter int P_TIMEOUT   = 1024
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  input  logic                   in_sclk,
  input  logic                   in_sdata,
  input  logic                   in_le,
  output logic                   out_valid,
  output logic [1:0]             out_addr,
  output logic [P_WORD_BITS-1:0] out_word,
  output logic [P_WORD_BITS-1:0] out_r_cnt,
  output logic [P_WORD_BITS-1:0] out_ctrl,
  output logic [P_WORD_BITS-1:0] out_n_cnt,
  output logic                   out_cfg_done,
  output logic                   out_err
);

  localparam int               L_TMR_W    = $clog2(P_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] L_WORD_CNT = CNT_W'(P_WORD_BITS);
  localparam logic [L_TMR_W-1:0] L_TMR_END = L_TMR_W'(P_TIMEOUT - 1);

  logic w_sclk_lvl_unused;
  logic w_sclk_rise;
  logic w_sdata_lvl;
  logic w_sdata_rise_unused;
  logic w_le_lvl;
  logic w_le_rise;

  adf_serial_rx_sync_edge u_sync_sclk (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_d(in_sclk),
    .out_lvl(w_sclk_lvl_unused), .out_rise(w_sclk_rise)
  );

  adf_serial_rx_sync_edge u_sync_sdata (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_d(in_sdata),
    .out_lvl(w_sdata_lvl), .out_rise(w_sdata_rise_unused)
  );

  adf_serial_rx_sync_edge u_sync_le (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_d(in_le),
    .out_lvl(w_le_lvl), .out_rise(w_le_rise)
  );

  state_t                 r_state;
  logic [P_WORD_BITS-1:0] r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [L_TMR_W-1:0]     r_timer;
  logic [2:0]             r_wr;     // written flags: {N, ctrl, R}
  logic [2:0]             w_wr_set;
  logic                   w_legal;

  always_comb begin
    w_wr_set = 3'b000;
    case (r_shift[1:0])
      ADDR_R:    w_wr_set = 3'b001;
      ADDR_CTRL: w_wr_set = 3'b010;
      ADDR_N:    w_wr_set = 3'b100;
      default:   w_wr_set = 3'b000;
    endcase
  end

  assign w_legal = (r_cnt == L_WORD_CNT) && (r_shift[1:0] != 2'b11);

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_wr         <= 3'b000;
      out_valid    <= LOW;
      out_addr     <= 2'b00;
      out_word     <= '0;
      out_r_cnt    <= '0;
      out_ctrl     <= '0;
      out_n_cnt    <= '0;
      out_cfg_done <= LOW;
      out_err      <= LOW;
    end else begin
      out_valid <= LOW;
      out_err   <= LOW;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          // LE has priority over a coincident SCLK edge
          if (w_sclk_rise && !w_le_lvl && !w_le_rise) begin
            r_shift <= {r_shift[P_WORD_BITS-2:0], w_sdata_lvl};
            r_cnt   <= 5'd1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_le_rise) begin
            r_state <= ST_LATCH;
          end else if (w_sclk_rise && !w_le_lvl) begin
            r_shift <= {r_shift[P_WORD_BITS-2:0], w_sdata_lvl};
            r_cnt   <= sat_inc(r_cnt);
            r_timer <= '0;
          end else if (r_timer == L_TMR_END) begin
            out_err <= HIGH;
            r_cnt   <= '0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_LATCH: begin
          if (w_legal) begin
            case (r_shift[1:0])
              ADDR_R:    out_r_cnt <= r_shift;
              ADDR_CTRL: out_ctrl  <= r_shift;
              ADDR_N:    out_n_cnt <= r_shift;
              default:   out_err   <= LOW;
            endcase
            out_word     <= r_shift;
            out_addr     <= r_shift[1:0];
            out_valid    <= HIGH;
            r_wr         <= r_wr | w_wr_set;
            out_cfg_done <= &(r_wr | w_wr_set);
          end else begin
            out_err <= HIGH;
          end
          r_cnt   <= '0;
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
